sel_mux_pipe: RTL and testbench
===============================

Name: sel_mux_pipe

Overview:
- Parametrised N-to-1 operand selector with an optional output pipeline register.
- Sits at stage boundaries of the pipelined MIPS core (forwarding/operand select feeding the ID/EX and EX/MEM registers).
- Generalises the fixed 3-input selector in three ways: input count and width are parameters; the output can be registered with stall/flush control; out-of-range selects are detected and latched for the exception path.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 3, number of inputs; legal range 2..16.
- SEL_W, $clog2(N), select width; a derived localparam, minimum 1.
- REG_OUT, 1. 1 = output registered (1-cycle latency); 0 = output combinational (0 latency). out_valid and sel_err are registered in both modes.
- FLUSH_VAL, 0, value loaded into dout on flush (WIDTH bits).

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_bus, input, N*WIDTH, flattened inputs; input i = in_bus[i*WIDTH +: WIDTH].
- sel, input, SEL_W, binary index of the selected input.
- in_valid, input, 1, the current sel/in_bus pair is meaningful.
- stall, input, 1, hold the register contents.
- flush, input, 1, insert a bubble.
- err_clr, input, 1, clears the sticky error flag.
- dout, output, WIDTH, selected data.
- out_valid, output, 1, dout carries valid data.
- sel_err, output, 1, sticky flag: an out-of-range select was seen with in_valid=1.
- err_idx, output, SEL_W, the sel value that first set sel_err.

Behaviour:
- Select:
  - pick = in_bus[sel*WIDTH +: WIDTH] when sel < N.
  - If sel >= N, pick = input 0. This is the default path and matches the legacy default-to-in0 rule.
- Reset (reset_n=0, asynchronous, immediate):
  - dout register = 0, out_valid = 0, sel_err = 0, err_idx = 0.
  - In REG_OUT=0, dout still follows pick combinationally during reset.
- Register update priority each rising edge (REG_OUT=1), highest first:
  - flush=1: dout <= FLUSH_VAL, out_valid <= 0. Flush wins over stall, because the exception/branch flush must kill a stalled slot.
  - else stall=1: dout and out_valid hold.
  - else: dout <= pick, out_valid <= in_valid.
- REG_OUT=0:
  - dout = pick with no latency; flush and stall do not affect dout.
  - out_valid is still registered with the same flush/stall/load priority, so it lags dout by 1 cycle. This is documented intentionally and is used only for error bookkeeping.
- Error latch:
  - Set: on an edge with in_valid=1, sel>=N, stall=0 and flush=0, sel_err <= 1. If sel_err was 0, err_idx <= sel at the same edge.
  - Hold: once set, sel_err stays 1 and err_idx holds (first-error capture).
  - Clear: err_clr=1 clears sel_err and err_idx to 0. If err_clr and a new error occur on the same edge, set wins: sel_err=1, err_idx=new sel.
  - When N is a power of two, sel>=N is impossible; sel_err stays 0 and the logic must synthesise away.
- Reset deasserted mid-stall: the register stays at its reset values until the first edge with stall=0.
- Input changes on in_bus during stall have no effect on dout (REG_OUT=1).
- No combinational path from stall/flush/err_clr to any output.

Test Plan:
- Reset and basic select: N=3, WIDTH=32, REG_OUT=1.
  - Release reset_n; drive in0=0x11111111, in1=0x22222222, in2=0x33333333, sel=2, in_valid=1.
  - After 1 edge: dout=0x33333333, out_valid=1. Before that edge: dout=0, out_valid=0.
- Stall hold: with dout=0x33333333, assert stall, change sel=1 and in1=0xDEADBEEF for 3 cycles.
  - dout stays 0x33333333. Drop stall: the next edge gives dout=0xDEADBEEF.
- Flush priority: assert stall=1 and flush=1 together, FLUSH_VAL=0.
  - Next edge: dout=0, out_valid=0. Stall alone afterwards keeps dout=0.
- Out-of-range select: N=3, sel=3, in_valid=1.
  - dout=in0 value. sel_err=1 and err_idx=3 after the edge.
  - Next, sel=3 again with err_clr=1 and in_valid=1: sel_err stays 1 (set wins).
  - Then err_clr=1 with sel=0: sel_err=0.
- Async reset mid-operation: pulse reset_n low for 2 ns between edges while out_valid=1, sel_err=1.
  - dout, out_valid, sel_err and err_idx all go to 0 immediately, without a clock edge.
- Generalised config: N=8, WIDTH=16, REG_OUT=0.
  - sel sweeps 0..7 with in_i=0x1000+i: dout=0x1000+sel in the same cycle.
  - sel_err is never set.

Source files
------------

// File: rtl/sel_mux_pipe_if.sv
// Operand-select bus: N flattened data inputs, binary select, pipeline
// controls (stall/flush/err_clr) and the selected result with its error flags.
// master drives the select request; slave (the selector) returns dout/flags.
interface sel_mux_pipe_if #(
   parameter int WIDTH = 32,
   parameter int N     = 3,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1
);
   logic [N*WIDTH-1:0] in_bus;
   logic [SEL_W-1:0]   sel;
   logic               in_valid;
   logic               stall;
   logic               flush;
   logic               err_clr;
   logic [WIDTH-1:0]   dout;
   logic               out_valid;
   logic               sel_err;
   logic [SEL_W-1:0]   err_idx;

   modport master (
      output in_bus, sel, in_valid, stall, flush, err_clr,
      input  dout, out_valid, sel_err, err_idx
   );

   modport slave (
      input  in_bus, sel, in_valid, stall, flush, err_clr,
      output dout, out_valid, sel_err, err_idx
   );
endinterface

// File: rtl/sel_mux_pipe.sv
// Purpose: N-to-1 operand selector with optional output register and a sticky
//          out-of-range select error latch (first offending index captured).
// Latency: REG_OUT=1 -> dout 1 cycle; REG_OUT=0 -> dout 0 cycles; out_valid,
//          sel_err and err_idx are always registered (1 cycle).
// Backpressure: stall holds dout/out_valid; flush overrides stall and loads a
//          bubble (FLUSH_VAL, out_valid=0). No comb path from stall/flush/err_clr.
// Ports: clk, reset_n (async active-low), bus (sel_mux_pipe_if.slave):
//        in_bus/sel/in_valid/stall/flush/err_clr in, dout/out_valid/sel_err/err_idx out.
module sel_mux_pipe #(
   parameter int               WIDTH     = 32,
   parameter int               N         = 3,
   parameter bit               REG_OUT   = 1'b1,
   parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
   input  logic          clk,
   input  logic          reset_n,
   sel_mux_pipe_if.slave bus
);
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
   localparam bit N_POW2 = ((N & (N - 1)) == 0);

   logic [WIDTH-1:0] pick;
   logic             sel_oor;
   logic             err_set;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   logic [SEL_W-1:0] idx_q, idx_d;

   // Unmatched (out-of-range) selects fall through to input 0.
   always_comb begin
      pick = bus.in_bus[WIDTH-1:0];
      for (int i = 1; i < N; i++) begin
         if (bus.sel == SEL_W'(i)) pick = bus.in_bus[i*WIDTH +: WIDTH];
      end
   end

   // With a power-of-two N every select code is legal, so the error path is
   // tied off and the latch reduces to constants.
   generate
      if (N_POW2) begin : g_no_oor
         assign sel_oor = 1'b0;
      end else begin : g_oor
         assign sel_oor = (bus.sel >= SEL_W'(N));
      end
   endgenerate

   // Errors are only recorded when the slot actually advances.
   assign err_set = bus.in_valid & sel_oor & ~bus.stall & ~bus.flush;

   always_comb begin
      vld_d = vld_q;
      if (bus.flush)       vld_d = 1'b0;
      else if (!bus.stall) vld_d = bus.in_valid;
   end

   // Set beats clear; a set coinciding with clear re-captures the new index.
   always_comb begin
      err_d = err_q;
      idx_d = idx_q;
      if (err_set) begin
         err_d = 1'b1;
         if (!err_q || bus.err_clr) idx_d = bus.sel;
      end else if (bus.err_clr) begin
         err_d = 1'b0;
         idx_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= 1'b0;
         err_q <= 1'b0;
         idx_q <= '0;
      end else begin
         vld_q <= vld_d;
         err_q <= err_d;
         idx_q <= idx_d;
      end
   end

   generate
      if (REG_OUT) begin : g_reg_out
         logic [WIDTH-1:0] dout_q, dout_d;

         always_comb begin
            dout_d = dout_q;
            if (bus.flush)       dout_d = FLUSH_VAL;
            else if (!bus.stall) dout_d = pick;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) dout_q <= '0;
            else          dout_q <= dout_d;
         end

         assign bus.dout = dout_q;
      end else begin : g_comb_out
         assign bus.dout = pick;
      end
   endgenerate

   assign bus.out_valid = vld_q;
   assign bus.sel_err   = err_q;
   assign bus.err_idx   = idx_q;
endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: config A (N=3, WIDTH=32, registered) and config B
// (N=8, WIDTH=16, combinational) side by side, directed scenarios followed by
// a randomized run against an array-based reference model.
module tb_sel_mux_pipe;
   logic clk;
   logic rst_n;

   int errors = 0;
   int checks = 0;

   sel_mux_pipe_if #(.WIDTH(32), .N(3)) ifa ();
   sel_mux_pipe_if #(.WIDTH(16), .N(8)) ifb ();

   sel_mux_pipe #(.WIDTH(32), .N(3), .REG_OUT(1'b1), .FLUSH_VAL(32'h0)) dut_a (
      .clk(clk), .reset_n(rst_n), .bus(ifa));
   sel_mux_pipe #(.WIDTH(16), .N(8), .REG_OUT(1'b0), .FLUSH_VAL(16'h0)) dut_b (
      .clk(clk), .reset_n(rst_n), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] ain [3];
   logic [15:0] bin [8];
   logic [31:0] ma_dout;
   logic        ma_vld, ma_err;
   logic [1:0]  ma_idx;
   logic        mb_vld;

   task automatic pack_inputs();
      for (int i = 0; i < 3; i++) ifa.in_bus[i*32 +: 32] = ain[i];
      for (int i = 0; i < 8; i++) ifb.in_bus[i*16 +: 16] = bin[i];
   endtask

   task automatic model_reset();
      ma_dout = '0; ma_vld = 1'b0; ma_err = 1'b0; ma_idx = '0; mb_vld = 1'b0;
   endtask

   // Advance one clock edge, applying the selector's rules to the model using
   // the inputs as they stand at the edge, then settle 1 ns past the edge.
   task automatic tick();
      logic [31:0] want;
      logic        oor, new_err;
      @(posedge clk);
      oor  = (int'(ifa.sel) >= 3);
      want = oor ? ain[0] : ain[int'(ifa.sel)];
      new_err = ifa.in_valid && oor && !ifa.stall && !ifa.flush;
      if (ifa.flush) begin
         ma_dout = 32'h0; ma_vld = 1'b0;
      end else if (!ifa.stall) begin
         ma_dout = want; ma_vld = ifa.in_valid;
      end
      if (new_err) begin
         if (!ma_err || ifa.err_clr) ma_idx = ifa.sel;
         ma_err = 1'b1;
      end else if (ifa.err_clr) begin
         ma_err = 1'b0; ma_idx = '0;
      end
      if (ifb.flush)       mb_vld = 1'b0;
      else if (!ifb.stall) mb_vld = ifb.in_valid;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ain[0] = 32'h11111111; ain[1] = 32'h22222222; ain[2] = 32'h33333333;
      for (int i = 0; i < 8; i++) bin[i] = 16'h1000 + 16'(i);
      pack_inputs();
      ifa.sel = 2'd2; ifa.in_valid = 1'b1; ifa.stall = 1'b0; ifa.flush = 1'b0; ifa.err_clr = 1'b0;
      ifb.sel = 3'd0; ifb.in_valid = 1'b0; ifb.stall = 1'b0; ifb.flush = 1'b0; ifb.err_clr = 1'b0;
      model_reset();
      #12;
      checks++; if (ifa.dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 00000000", ifa.dout); end
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ifa.out_valid); end
      checks++; if (ifa.sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b want 0", ifa.sel_err); end
      checks++; if (ifa.err_idx !== 2'd0) begin errors++; $display("FAIL reset_err_idx: got %0d want 0", ifa.err_idx); end
      checks++; if (ifb.dout !== 16'h1000) begin errors++; $display("FAIL reset_comb_dout: got %h want 1000", ifb.dout); end
      checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b want 0", ifb.out_valid); end
   endtask

   task automatic test_basic_select();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (ifa.dout !== 32'h0) begin errors++; $display("FAIL basic_pre_dout: got %h want 00000000", ifa.dout); end
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid: got %b want 0", ifa.out_valid); end
      tick();
      checks++; if (ifa.dout !== 32'h33333333) begin errors++; $display("FAIL basic_dout: got %h want 33333333", ifa.dout); end
      checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", ifa.out_valid); end
   endtask

   task automatic test_stall_hold();
      ifa.stall = 1'b1; ifa.sel = 2'd1; ain[1] = 32'hDEADBEEF; pack_inputs();
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (ifa.dout !== 32'h33333333) begin errors++; $display("FAIL stall_hold[%0d]: got %h want 33333333", c, ifa.dout); end
      end
      ifa.stall = 1'b0;
      tick();
      checks++; if (ifa.dout !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_release: got %h want deadbeef", ifa.dout); end
   endtask

   task automatic test_flush_priority();
      ifa.stall = 1'b1; ifa.flush = 1'b1;
      tick();
      checks++; if (ifa.dout !== 32'h0) begin errors++; $display("FAIL flush_dout: got %h want 00000000", ifa.dout); end
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ifa.out_valid); end
      ifa.flush = 1'b0; ifa.sel = 2'd2;
      tick();
      checks++; if (ifa.dout !== 32'h0) begin errors++; $display("FAIL flush_then_stall: got %h want 00000000", ifa.dout); end
      ifa.stall = 1'b0;
   endtask

   task automatic test_out_of_range();
      // Out-of-range select while stalled or invalid must not record an error.
      ifa.sel = 2'd3; ifa.in_valid = 1'b1; ifa.stall = 1'b1;
      tick();
      checks++; if (ifa.sel_err !== 1'b0) begin errors++; $display("FAIL oor_stalled: got %b want 0", ifa.sel_err); end
      ifa.stall = 1'b0; ifa.in_valid = 1'b0;
      tick();
      checks++; if (ifa.sel_err !== 1'b0) begin errors++; $display("FAIL oor_invalid: got %b want 0", ifa.sel_err); end
      ifa.in_valid = 1'b1;
      tick();
      checks++; if (ifa.dout !== 32'h11111111) begin errors++; $display("FAIL oor_default_in0: got %h want 11111111", ifa.dout); end
      checks++; if (ifa.sel_err !== 1'b1) begin errors++; $display("FAIL oor_set: got %b want 1", ifa.sel_err); end
      checks++; if (ifa.err_idx !== 2'd3) begin errors++; $display("FAIL oor_idx: got %0d want 3", ifa.err_idx); end
      ifa.err_clr = 1'b1;
      tick();
      checks++; if (ifa.sel_err !== 1'b1) begin errors++; $display("FAIL oor_set_wins: got %b want 1", ifa.sel_err); end
      checks++; if (ifa.err_idx !== 2'd3) begin errors++; $display("FAIL oor_set_wins_idx: got %0d want 3", ifa.err_idx); end
      ifa.sel = 2'd0;
      tick();
      checks++; if (ifa.sel_err !== 1'b0) begin errors++; $display("FAIL oor_clear: got %b want 0", ifa.sel_err); end
      checks++; if (ifa.err_idx !== 2'd0) begin errors++; $display("FAIL oor_clear_idx: got %0d want 0", ifa.err_idx); end
      ifa.err_clr = 1'b0;
   endtask

   task automatic test_async_reset();
      ifa.sel = 2'd3; ifa.in_valid = 1'b1;
      tick();
      checks++; if (ifa.out_valid !== 1'b1 || ifa.sel_err !== 1'b1) begin errors++; $display("FAIL async_setup: got valid=%b err=%b want 1 1", ifa.out_valid, ifa.sel_err); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (ifa.dout !== 32'h0) begin errors++; $display("FAIL async_dout: got %h want 00000000", ifa.dout); end
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", ifa.out_valid); end
      checks++; if (ifa.sel_err !== 1'b0) begin errors++; $display("FAIL async_sel_err: got %b want 0", ifa.sel_err); end
      checks++; if (ifa.err_idx !== 2'd0) begin errors++; $display("FAIL async_err_idx: got %0d want 0", ifa.err_idx); end
      ifa.stall = 1'b1; ifa.sel = 2'd2;
      #1 rst_n = 1'b1;
      model_reset();
      tick();
      checks++; if (ifa.dout !== 32'h0 || ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_stall: got dout=%h valid=%b want 00000000 0", ifa.dout, ifa.out_valid); end
      ifa.stall = 1'b0;
      tick();
      checks++; if (ifa.dout !== 32'h33333333) begin errors++; $display("FAIL reset_release_load: got %h want 33333333", ifa.dout); end
   endtask

   task automatic test_wide_comb();
      for (int s = 0; s < 8; s++) begin
         ifb.sel = 3'(s); ifb.in_valid = 1'b1; ifb.flush = (s == 5); ifb.stall = (s == 6);
         #1;
         checks++; if (ifb.dout !== 16'h1000 + 16'(s)) begin errors++; $display("FAIL comb_sweep[%0d]: got %h want %h", s, ifb.dout, 16'h1000 + 16'(s)); end
         tick();
         checks++; if (ifb.sel_err !== 1'b0) begin errors++; $display("FAIL comb_no_err[%0d]: got %b want 0", s, ifb.sel_err); end
      end
      ifb.flush = 1'b0; ifb.stall = 1'b0;
      tick();
      checks++; if (ifb.out_valid !== 1'b1) begin errors++; $display("FAIL comb_out_valid: got %b want 1", ifb.out_valid); end
   endtask

   task automatic test_random();
      logic [15:0] bwant;
      rst_n = 1'b0; #2; rst_n = 1'b1;
      model_reset();
      for (int it = 0; it < 300; it++) begin
         for (int i = 0; i < 3; i++) ain[i] = $urandom;
         for (int i = 0; i < 8; i++) bin[i] = 16'($urandom);
         pack_inputs();
         ifa.sel = 2'($urandom_range(0, 3));
         ifa.in_valid = ($urandom_range(0, 3) != 0);
         ifa.stall = ($urandom_range(0, 3) == 0);
         ifa.flush = ($urandom_range(0, 9) == 0);
         ifa.err_clr = ($urandom_range(0, 6) == 0);
         ifb.sel = 3'($urandom_range(0, 7));
         ifb.in_valid = $urandom_range(0, 1) == 1;
         ifb.stall = ($urandom_range(0, 3) == 0);
         ifb.flush = ($urandom_range(0, 9) == 0);
         ifb.err_clr = ($urandom_range(0, 6) == 0);
         #1;
         bwant = bin[int'(ifb.sel)];
         checks++; if (ifb.dout !== bwant) begin errors++; $display("FAIL rnd_b_dout[%0d]: got %h want %h", it, ifb.dout, bwant); end
         tick();
         checks++; if (ifa.dout !== ma_dout) begin errors++; $display("FAIL rnd_a_dout[%0d]: got %h want %h", it, ifa.dout, ma_dout); end
         checks++; if (ifa.out_valid !== ma_vld) begin errors++; $display("FAIL rnd_a_valid[%0d]: got %b want %b", it, ifa.out_valid, ma_vld); end
         checks++; if (ifa.sel_err !== ma_err) begin errors++; $display("FAIL rnd_a_err[%0d]: got %b want %b", it, ifa.sel_err, ma_err); end
         checks++; if (ifa.err_idx !== ma_idx) begin errors++; $display("FAIL rnd_a_idx[%0d]: got %0d want %0d", it, ifa.err_idx, ma_idx); end
         checks++; if (ifb.out_valid !== mb_vld) begin errors++; $display("FAIL rnd_b_valid[%0d]: got %b want %b", it, ifb.out_valid, mb_vld); end
         checks++; if (ifb.sel_err !== 1'b0) begin errors++; $display("FAIL rnd_b_err[%0d]: got %b want 0", it, ifb.sel_err); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_select();
      test_stall_hold();
      test_flush_priority();
      test_out_of_range();
      test_async_reset();
      test_wide_comb();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
